// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the 8-bit SPI master.
package spi_pkg;
  localparam int DATA_W = 8;
  localparam int BIT_W  = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;
endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator; counter held at zero while disabled.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_master.sv
// Mode-0, LSB-first 8-bit SPI master with optional
// trailing sclk pulses after each frame.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int IDLE_PULSES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              ss,
  output logic              MOSI,
  input  logic              MISO
);
  localparam int GAP_W = $clog2(2 * IDLE_PULSES + 2);
  localparam int GAP_N =
    (IDLE_PULSES > 0) ? 2 * IDLE_PULSES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_N);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] LAST_TX  = BIT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              tick;

  // Every transition lands on a tick, so the divider
  // is already at zero on entry to each state.
  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (state != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ss       <= 1'b1;
      sclk     <= 1'b0;
      MOSI     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          ss      <= 1'b1;
          sclk    <= 1'b0;
          MOSI    <= 1'b1;
          bit_cnt <= '0;
          gap_cnt <= '0;
          if (start && !busy) begin
            tx_shift <= tx_data;
            ss       <= 1'b0;
            MOSI     <= tx_data[0];
            busy     <= 1'b1;
            state    <= SETUP;
          end else begin
            busy <= 1'b0;
          end
        end
        SETUP: begin
          if (tick) begin
            sclk     <= 1'b1;
            rx_shift <= {MISO, rx_shift[DATA_W-1:1]};
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (sclk) begin
              sclk    <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt < LAST_TX) begin
                tx_shift <= tx_shift >> 1;
                MOSI     <= tx_shift[1];
              end
            end else if (bit_cnt == LAST_BIT) begin
              state <= HOLD;
            end else begin
              sclk     <= 1'b1;
              rx_shift <= {MISO, rx_shift[DATA_W-1:1]};
            end
          end
        end
        HOLD: begin
          if (tick) begin
            ss      <= 1'b1;
            MOSI    <= 1'b1;
            rx_data <= rx_shift;
            done    <= 1'b1;
            if (IDLE_PULSES > 0) begin
              sclk  <= 1'b1;
              state <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
            end else begin
              sclk    <= ~sclk;
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances with different
// divider/gap settings, a bus monitor and a byte-level model.
module tb_spi_master;
  logic       clk = 1'b0;
  logic [2:0] reset_n;
  logic [2:0] start;
  logic [7:0] tx_data [3];
  logic [2:0] busy, done, sclk, ss, mosi, miso;
  logic [7:0] rx_data [3];

  int         miso_mode [3];
  logic [7:0] slave_byte [3];

  int         vectors = 0;
  int         miscompares = 0;

  int         cur_len [3] = '{default: 0};
  int         cur_rises [3] = '{default: 0};
  logic [7:0] cur_mosi [3];
  int         first_rise [3] = '{default: 0};
  int         frame_len [3] = '{default: 0};
  int         frame_rises [3] = '{default: 0};
  logic [7:0] frame_mosi [3];
  int         frame_first [3] = '{default: 0};
  int         frames [3] = '{default: 0};
  int         done_cnt [3] = '{default: 0};
  int         gap_busy [3] = '{default: 0};
  int         gap_rises [3] = '{default: 0};
  int         last_gap_busy [3] = '{default: 0};
  int         last_gap_rises [3] = '{default: 0};
  int         idle_len [3] = '{default: 0};
  int         last_idle_len [3] = '{default: 0};
  int         idle_sclk [3] = '{default: 0};
  logic [2:0] psclk, pss, pbusy;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(2), .IDLE_PULSES(0)) u0 (
    .clk(clk), .reset_n(reset_n[0]), .start(start[0]),
    .tx_data(tx_data[0]), .busy(busy[0]), .done(done[0]),
    .rx_data(rx_data[0]), .sclk(sclk[0]), .ss(ss[0]),
    .MOSI(mosi[0]), .MISO(miso[0])
  );

  spi_master u1 (
    .clk(clk), .reset_n(reset_n[1]), .start(start[1]),
    .tx_data(tx_data[1]), .busy(busy[1]), .done(done[1]),
    .rx_data(rx_data[1]), .sclk(sclk[1]), .ss(ss[1]),
    .MOSI(mosi[1]), .MISO(miso[1])
  );

  spi_master #(.CLK_DIV(1), .IDLE_PULSES(0)) u2 (
    .clk(clk), .reset_n(reset_n[2]), .start(start[2]),
    .tx_data(tx_data[2]), .busy(busy[2]), .done(done[2]),
    .rx_data(rx_data[2]), .sclk(sclk[2]), .ss(ss[2]),
    .MOSI(mosi[2]), .MISO(miso[2])
  );

  // Slave side: loopback, tied 0, tied 1, or a byte
  // presented LSB first, advancing after each rising edge.
  always_comb begin
    miso = '0;
    for (int i = 0; i < 3; i++) begin
      case (miso_mode[i])
        0:       miso[i] = mosi[i];
        1:       miso[i] = 1'b0;
        2:       miso[i] = 1'b1;
        default: miso[i] = slave_byte[i][3'(cur_rises[i])];
      endcase
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n[i]) begin
        cur_len[i]   = 0;
        cur_rises[i] = 0;
        gap_busy[i]  = 0;
        gap_rises[i] = 0;
        idle_len[i]  = 0;
        psclk[i]     = 1'b0;
        pss[i]       = 1'b1;
        pbusy[i]     = 1'b0;
      end else begin
        if (!ss[i]) begin
          cur_len[i]++;
          if (sclk[i] && !psclk[i]) begin
            if (cur_rises[i] == 0)
              first_rise[i] = cur_len[i] - 1;
            if (cur_rises[i] < 8)
              cur_mosi[i][3'(cur_rises[i])] = mosi[i];
            cur_rises[i]++;
          end
        end else begin
          if (!pss[i]) begin
            frame_len[i]   = cur_len[i];
            frame_rises[i] = cur_rises[i];
            frame_mosi[i]  = cur_mosi[i];
            frame_first[i] = first_rise[i];
            frames[i]++;
            cur_len[i]     = 0;
            cur_rises[i]   = 0;
            gap_busy[i]    = 0;
            gap_rises[i]   = 0;
          end
          if (busy[i]) gap_busy[i]++;
          if (sclk[i] && !psclk[i]) gap_rises[i]++;
        end
        if (done[i]) done_cnt[i]++;
        if (!busy[i]) begin
          idle_len[i]++;
          if (sclk[i]) idle_sclk[i]++;
        end
        if (pbusy[i] && !busy[i]) begin
          last_gap_busy[i]  = gap_busy[i];
          last_gap_rises[i] = gap_rises[i];
        end
        if (!pbusy[i] && busy[i]) begin
          last_idle_len[i] = idle_len[i];
          idle_len[i]      = 0;
        end
        psclk[i] = sclk[i];
        pss[i]   = ss[i];
        pbusy[i] = busy[i];
      end
    end
  end

  function automatic int cd_of(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  function automatic int ip_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic logic [7:0] model_rx(
    input int m, input logic [7:0] tx, input logic [7:0] sb
  );
    case (m)
      0:       return tx;
      1:       return 8'h00;
      2:       return 8'hFF;
      default: return sb;
    endcase
  endfunction

  task automatic check(
    input string name, input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic poll();
    @(negedge clk);
    #1;
  endtask

  task automatic run_frame(
    input int i, input int m, input logic [7:0] tx,
    input logic [7:0] sb, input logic [7:0] exp
  );
    int f0, d0, n;
    miso_mode[i]  = m;
    slave_byte[i] = sb;
    n = 0;
    while (busy[i] && n < 200) begin poll(); n++; end
    f0 = frames[i];
    d0 = done_cnt[i];
    @(negedge clk);
    start[i]   = 1'b1;
    tx_data[i] = tx;
    @(posedge clk);
    #1;
    start[i]   = 1'b0;
    tx_data[i] = ~tx;
    check("accept", {busy[i], ss[i]}, 2'b10);
    n = 0;
    while ((frames[i] == f0 || busy[i]) && n < 400) begin
      poll();
      n++;
    end
    check("frame_timeout", n < 400, 1);
    check("rx_data", rx_data[i], exp);
    check("ss_len", frame_len[i], 18 * cd_of(i));
    check("rises", frame_rises[i], 8);
    check("mosi_bits", frame_mosi[i], tx);
    check("first_rise", frame_first[i], cd_of(i));
    check("done_pulses", done_cnt[i] - d0, 1);
    check("gap_pulses", last_gap_rises[i], ip_of(i));
    check("busy_tail", last_gap_busy[i],
          2 * ip_of(i) * cd_of(i) + 1);
  endtask

  typedef struct {
    int         inst;
    int         mode;
    logic [7:0] tx;
    logic [7:0] sb;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl [7];
  int         f0, d0, n, ri, rm;
  logic [7:0] rt, rs;

  initial begin
    tbl[0] = '{0, 0, 8'hA5, 8'h00, 8'hA5};
    tbl[1] = '{0, 1, 8'hFF, 8'h00, 8'h00};
    tbl[2] = '{0, 2, 8'h00, 8'h00, 8'hFF};
    tbl[3] = '{0, 3, 8'h3C, 8'h96, 8'h96};
    tbl[4] = '{2, 0, 8'h01, 8'h00, 8'h01};
    tbl[5] = '{2, 0, 8'h80, 8'h00, 8'h80};
    tbl[6] = '{1, 0, 8'h5A, 8'h00, 8'h5A};

    reset_n = '0;
    start   = '0;
    for (int i = 0; i < 3; i++) begin
      tx_data[i]    = 8'h00;
      miso_mode[i]  = 0;
      slave_byte[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss", ss, 3'b111);
    check("rst_sclk", sclk, 3'b000);
    check("rst_mosi", mosi, 3'b111);
    check("rst_busy", busy, 3'b000);
    check("rst_done", done, 3'b000);
    check("rst_rx", rx_data[0], 8'h00);
    @(negedge clk);
    reset_n = '1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 7; k++)
      run_frame(tbl[k].inst, tbl[k].mode, tbl[k].tx,
                tbl[k].sb, tbl[k].exp);

    // start held high on the default instance
    f0 = frames[1];
    d0 = done_cnt[1];
    miso_mode[1] = 0;
    @(negedge clk);
    start[1]   = 1'b1;
    tx_data[1] = 8'h3C;
    n = 0;
    while (ss[1] && n < 50) begin poll(); n++; end
    repeat (10) @(posedge clk);
    #1;
    tx_data[1] = 8'hC3;
    n = 0;
    while (frames[1] == f0 && n < 200) begin poll(); n++; end
    check("hold_mosi1", frame_mosi[1], 8'h3C);
    check("hold_rx1", rx_data[1], 8'h3C);
    n = 0;
    while (frames[1] != f0 + 2 && n < 300) begin
      poll();
      n++;
    end
    check("hold_timeout", n < 300, 1);
    check("hold_mosi2", frame_mosi[1], 8'hC3);
    check("hold_gap", last_gap_rises[1], 2);
    check("hold_tail", last_gap_busy[1], 9);
    check("hold_idle", last_idle_len[1], 1);
    check("hold_done", done_cnt[1] - d0, 2);
    start[1] = 1'b0;
    n = 0;
    while (busy[1] && n < 100) begin poll(); n++; end

    // reset mid-frame after the 3rd rising edge
    d0 = done_cnt[1];
    @(negedge clk);
    start[1]   = 1'b1;
    tx_data[1] = 8'h6B;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    n = 0;
    while (cur_rises[1] < 3 && n < 100) begin poll(); n++; end
    #2;
    reset_n[1] = 1'b0;
    #1;
    check("abort_ss", ss[1], 1'b1);
    check("abort_sclk", sclk[1], 1'b0);
    check("abort_mosi", mosi[1], 1'b1);
    check("abort_busy", busy[1], 1'b0);
    check("abort_rx", rx_data[1], 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("abort_done", done_cnt[1] - d0, 0);
    @(negedge clk);
    reset_n[1] = 1'b1;
    run_frame(1, 0, 8'h6B, 8'h00, 8'h6B);

    for (int k = 0; k < 24; k++) begin
      ri = ($urandom_range(0, 1) == 0) ? 0 : 2;
      rm = int'($urandom_range(0, 3));
      rt = 8'($urandom);
      rs = 8'($urandom);
      run_frame(ri, rm, rt, rs, model_rx(rm, rt, rs));
    end

    for (int i = 0; i < 3; i++)
      check("idle_sclk", idle_sclk[i], 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
